// File: rtl/alu_result_stage.sv
// Purpose: registered result stage behind ALU/shifter/multiplier. It keeps HI/LO for MULTU and buffers results in a 2-entry FIFO.
// Latency: an accepted non-MULTU op is at out_valid/dataOut the next cycle when the FIFO was empty; otherwise it follows older entries in order.
// Backpressure: in_ready drops when the FIFO is full or a multiply is pending; optional macro ALU_OVERLAP_EN lets ALU/SLL ops through during a multiply.
module alu_result_stage #(
    parameter int MUL_TIMEOUT = 40,
    parameter int CNT_W       = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  Signal,
    input  logic [31:0] alu_result,
    input  logic [31:0] shift_result,
    input  logic [63:0] mul_product,
    input  logic        mul_done,
    output logic        mul_start,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] dataOut,
    output logic        err
);

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MUL_TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT_MUL} state_t;

    state_t           state_q, state_d;
    logic             run_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      hi_q, lo_q;
    logic [31:0]      mem_q [2];
    logic             rd_ptr_q, wr_ptr_q;
    logic [1:0]       fifo_count_q;
    logic [31:0]      last_q;
    logic             is_mul, is_hilo, xfer, push, pop, mul_issue, timeout;
    logic [31:0]      push_dat;

    assign is_mul  = (Signal == F_MULTU);
    assign is_hilo = (Signal == F_MFHI) || (Signal == F_MFLO);

    // Select the result that belongs to the presented function code
    always_comb begin
        push_dat = 32'b0;
        case (Signal)
            F_ADD, F_SUB, F_AND, F_OR, F_SLT: push_dat = alu_result;
            F_SLL:                            push_dat = shift_result;
            F_MFHI:                           push_dat = hi_q;
            F_MFLO:                           push_dat = lo_q;
            default:                          push_dat = 32'b0;
        endcase
    end

    // Acceptance: never during reset, FIFO space in IDLE, multiply gating in WAIT_MUL
    always_comb begin
        in_ready = 1'b0;
        if (run_q) begin
            case (state_q)
                IDLE:     in_ready = (fifo_count_q < 2'd2);
`ifdef ALU_OVERLAP_EN
                WAIT_MUL: in_ready = (fifo_count_q < 2'd2) && !is_mul && !is_hilo;
`else
                WAIT_MUL: in_ready = 1'b0;
`endif
                default:  in_ready = 1'b0;
            endcase
        end
    end

    assign xfer      = in_valid && in_ready;
    assign push      = xfer && !is_mul;
    assign mul_issue = xfer && is_mul;
    assign out_valid = (fifo_count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign dataOut   = out_valid ? mem_q[rd_ptr_q] : last_q;
    assign timeout   = (state_q == WAIT_MUL) && !mul_done && (cnt_q == TO_LAST);

    // Next state: MULTU issue enters WAIT_MUL, completion or timeout leaves it
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mul_issue) state_d = WAIT_MUL;
            WAIT_MUL: if (mul_done || cnt_q == TO_LAST) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // State register; run_q holds in_ready low until reset is released
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= 1'b1;
        end
    end

    // Multiply control: start pulse, timeout counter, HI/LO capture, sticky error
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mul_start <= 1'b0;
            cnt_q     <= '0;
            hi_q      <= 32'b0;
            lo_q      <= 32'b0;
            err       <= 1'b0;
        end else begin
            mul_start <= mul_issue;
            if (mul_issue) begin
                cnt_q <= '0;
            end else if (state_q == WAIT_MUL) begin
                cnt_q <= cnt_q + 1'b1;
            end
            if (state_q == WAIT_MUL && mul_done) begin
                hi_q <= mul_product[63:32];
                lo_q <= mul_product[31:0];
            end
            if (timeout) begin
                err <= 1'b1;
            end
        end
    end

    // Two-entry FIFO; last_q keeps the most recently popped word for the empty case
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0]     <= 32'b0;
            mem_q[1]     <= 32'b0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            fifo_count_q <= 2'd0;
            last_q       <= 32'b0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= push_dat;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, pop})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

endmodule
